// File: rtl/tow_scorer.sv
// tow_scorer: tug-of-war rope position, round/false-start detection, scoring and LED bar
module tow_scorer #(
    parameter int HALF      = 3,
    parameter int MAX_SCORE = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_l,
    input  logic              pb_r,
    input  logic              clear,
    input  logic              leds_on,
    input  logic [1:0]        led_control,
    output logic              winrnd,
    output logic              winner,
    output logic [3:0]        score_l,
    output logic [3:0]        score_r,
    output logic              match_over,
    output logic [2*HALF:0]   leds
);
    localparam int N  = 2*HALF + 1;
    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] CTR = PW'(HALF);
    localparam logic [PW-1:0] TOP = PW'(2*HALF);
    localparam logic [3:0]    MAX = 4'(MAX_SCORE);

    typedef enum logic [2:0] {S_HOLD, S_DARK, S_PLAY, S_WON, S_OVER} state_t;

    state_t        st, st_n;
    logic [PW-1:0] pos, pos_n, lp;
    logic [3:0]    sl_n, sr_n;
    logic [N-1:0]  oh, leds_n;
    logic          pb_l_d, pb_r_d, press_l, press_r, win, win_who, mo_n, lm;

    always_comb begin
        press_l = pb_l & ~pb_l_d;
        press_r = pb_r & ~pb_r_d;
        st_n    = st;
        pos_n   = pos;
        win     = 1'b0;
        win_who = winner;
        case (st)
            S_HOLD: if (!clear) begin
                pos_n = CTR;
                st_n  = leds_on ? S_PLAY : S_DARK;
            end
            S_DARK: if (press_l ^ press_r) begin
                // a false start hands the round to the other player
                win     = 1'b1;
                win_who = press_l;
                pos_n   = press_l ? TOP : '0;
            end else if (clear) st_n = S_HOLD;
            else if (leds_on) st_n = S_PLAY;
            S_PLAY: begin
                pos_n = (press_l & ~press_r) ? pos - PW'(1) :
                        (press_r & ~press_l) ? pos + PW'(1) : pos;
                if ((press_l ^ press_r) && (pos_n == '0 || pos_n == TOP)) begin
                    win     = 1'b1;
                    win_who = pos_n == TOP;
                end else if (clear) st_n = S_HOLD;
            end
            S_WON: if (clear) st_n = match_over ? S_OVER : S_HOLD;
            default: ;
        endcase
        if (win) st_n = S_WON;
        sl_n   = (win && !win_who && score_l != MAX) ? score_l + 4'd1 : score_l;
        sr_n   = (win &&  win_who && score_r != MAX) ? score_r + 4'd1 : score_r;
        mo_n   = match_over | (sl_n == MAX) | (sr_n == MAX);
        lp     = rst ? pos_n : CTR;
        lm     = rst & mo_n;
        oh     = {{(N-1){1'b0}}, 1'b1} << lp;
        leds_n = (lm || (leds_on && led_control == 2'b10)) ? oh :
                 (leds_on && led_control[0]) ? '1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_HOLD;
            pos        <= CTR;
            pb_l_d     <= 1'b1;
            pb_r_d     <= 1'b1;
            winrnd     <= 1'b0;
            winner     <= 1'b0;
            score_l    <= '0;
            score_r    <= '0;
            match_over <= 1'b0;
        end else begin
            st         <= st_n;
            pos        <= pos_n;
            pb_l_d     <= pb_l;
            pb_r_d     <= pb_r;
            winrnd     <= win;
            winner     <= win_who;
            score_l    <= sl_n;
            score_r    <= sr_n;
            match_over <= mo_n;
        end
        leds <= leds_n;
    end
endmodule
